fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the in-order RISC-V pipeline, directly upstream of the decoder. Generates sequential PCs, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. Presents `{pc, inst}` to decode with a valid flag. Handles decode stalls from the hazard eliminator and flushes on branch/jump redirects from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: fetch FIFO entries and in-flight request bound; power of two, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_resp_valid` in 1: response valid. In request order, latency ≥1 cycle, no backpressure.
- `imem_resp_data` in 32: instruction word.
- `redirect_valid` in 1: flush and restart fetch (taken branch, JAL, JALR).
- `redirect_pc` in 32: restart address; bits [1:0] ignored (treated as 0).
- `id_stall` in 1: decode cannot accept this cycle.
- `id_valid` out 1: `id_inst`/`id_pc` hold a live instruction.
- `id_inst` out 32: instruction; 32'h0000_0013 (NOP) when `id_valid`=0.
- `id_pc` out 32: PC of `id_inst`; 0 when `id_valid`=0.

## Operation
- **State:**
  - `pc` (next fetch address).
  - FIFO of `{pc, inst}` with `count`.
  - `outstanding`: live requests accepted but not yet answered.
  - `drop`: stale requests whose responses must be discarded.
  - Counters are width clog2(DEPTH)+1.
- **Issue:**
  - `imem_req_valid` = !rst && (outstanding + drop + count − pop) < DEPTH, where pop = id_valid && !id_stall.
  - `imem_req_addr` = `pc`.
  - Accept = valid && ready. On accept: `pc` += 4, wrapping 32'hFFFF_FFFC → 0, and `outstanding`++.
  - `pc` and address hold while valid && !ready.
- **Response:**
  - If `drop` > 0: discard the word, `drop`−−.
  - Otherwise: push `{pc_tag, data}` and `outstanding`−−.
  - `pc_tag` comes from a DEPTH-entry in-order tag queue written on accept.
- **Output:** FIFO head drives `id_*` and is registered (no response-to-output bypass). Pop when id_valid && !id_stall. `id_stall` with `id_valid`=0 has no effect.
- **Redirect** has priority over everything else in the same cycle:
  - FIFO and tag queue are cleared; `pc` ← {redirect_pc[31:2], 2'b00}.
  - `drop` ← drop + outstanding + accept − resp_valid; `outstanding` ← 0.
  - A response arriving in the redirect cycle is discarded.
  - A request accepted in the redirect cycle carries the old `pc` and is counted as stale.
  - No pop occurs in the redirect cycle.
- **Simultaneous push and pop** with FIFO full is legal; `count` is unchanged.

## Timing
- **Reset values:**
  - `imem_req_valid`=0, `id_valid`=0, `id_inst`=32'h13, `id_pc`=0.
  - `pc`=RESET_PC; count, outstanding and drop all 0.
  - Instruction memory is reset by the same `rst`, so no stale responses survive reset.
- **Reset mid-operation:** all in-flight state is discarded. First request in the first cycle with `rst`=0.
- **Latency:** request accepted cycle N, response in cycle N+L (L≥1), `id_valid` in cycle N+L+1.
- **Throughput:** with L=1, DEPTH=2 and no stalls, one instruction per cycle in steady state.
- **Redirect:** asserted in cycle R gives `id_valid`=0 in R+1. First request to the new PC is issued in R+1 if credit allows. Stale responses never reach `id_*`.
- **Combinational paths:** `imem_req_valid` depends combinationally on `id_stall` (through pop). There is no combinational path from `redirect_*` or `imem_resp_*` to any output.

## Test plan
- **Reset start:** RESET_PC=32'h100, 1-cycle memory, `imem_req_ready`=1, no stall. Required:
  - First request addr 0x100 in the first cycle after reset.
  - `id_pc` sequence 0x100, 0x104, 0x108… one per cycle.
  - First `id_valid` 2 cycles after the first accept.
- **Decode stall:** hold `id_stall` 4 cycles with FIFO full. Required:
  - `id_inst`/`id_pc` stable and `imem_req_valid`=0.
  - After release, consecutive PCs with no gap, loss or duplicate.
- **Stale responses:** 3-cycle memory with 2 requests in flight, redirect to 32'h200. Required:
  - Both stale responses dropped and `drop` returns to 0.
  - Next `id_pc`=0x200.
- **Same-cycle collisions:** redirect to 32'h203 in the same cycle as a response and an accepted request. Required:
  - Response discarded and the accepted request counted as stale.
  - Next request addr 0x200; no stale `id_valid`.
- **Memory backpressure:** random `imem_req_ready` low. Required:
  - `imem_req_addr` stable while valid && !ready.
  - Delivered PC stream strictly +4.
- **Wrap and reset:** start `pc` at 32'hFFFF_FFF8. Required:
  - Addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - `rst` pulsed mid-stream returns every output to its reset value in the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited imem requests,
// in-order response FIFO feeding decode, redirect flush with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [31:0]   pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   tag_q     [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0] count, outstanding, drop;
    logic [CW:0]   occ;
    logic          accept, pop, push, resp_drop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign id_inst  = id_valid ? fifo_inst[rd_ptr] : 32'h0000_0013;
    assign pop      = id_valid && !id_stall;

    // Credit: every in-flight or buffered word owns a FIFO slot, so pushes never overflow.
    assign occ = {1'b0, outstanding} + {1'b0, drop} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign imem_req_valid = !rst && (occ < DEPTH_C);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign resp_drop = (drop != '0);
    assign push      = imem_resp_valid && !resp_drop && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else if (redirect_valid) begin
            // Everything live becomes stale, including a request accepted this cycle.
            pc          <= {redirect_pc[31:2], 2'b00};
            count       <= '0;
            outstanding <= '0;
            drop        <= drop + outstanding + CW'(accept) - CW'(imem_resp_valid);
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            if (accept) begin
                pc     <= pc + 32'd4;
                tag_wr <= tag_wr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                tag_rd <= tag_rd + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(push);
            drop        <= drop - CW'(imem_resp_valid && resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (accept)
                tag_q[tag_wr] <= pc;
            if (push) begin
                fifo_pc[wr_ptr]   <= tag_q[tag_rd];
                fifo_inst[wr_ptr] <= imem_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency in-order memory model, vector
// table for streaming/stall, hand sequences for redirect, backpressure, wrap, reset.
module tb_fetch_unit;
    logic        clk, rst, ready, resp_valid, redir, stall;
    logic [31:0] resp_data, rpc;
    logic        req_valid, id_valid;
    logic [31:0] req_addr, id_inst, id_pc;

    int checks = 0, errors = 0, cyc = 0, lat = 1;

    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t pend[$];

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[13];

    fetch_unit #(.RESET_PC(32'h100), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redir), .redirect_pc(rpc),
        .id_stall(stall), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_id(input string nm, input logic iv, input logic [31:0] pc);
        chk({nm, " id_valid"}, 32'(id_valid), 32'(iv));
        chk({nm, " id_pc"}, id_pc, iv ? pc : 32'h0);
        chk({nm, " id_inst"}, id_inst, iv ? ~pc : 32'h13);
    endtask

    task automatic chk_out(input string nm, input logic rv, input logic [31:0] addr,
                           input logic iv, input logic [31:0] pc);
        chk({nm, " req_valid"}, 32'(req_valid), 32'(rv));
        if (rv) chk({nm, " req_addr"}, req_addr, addr);
        chk_id(nm, iv, pc);
    endtask

    // Memory model: responds ~addr, in order, lat cycles after accept; reset by rst.
    task automatic tick();
        logic        acc, was_rst;
        logic [31:0] a;
        pend_t       p;
        #1;
        acc = req_valid && ready;
        a = req_addr;
        was_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) pend.delete();
        else begin
            if (resp_valid) void'(pend.pop_front());
            if (acc) begin
                p.due = cyc - 1 + lat;
                p.addr = a;
                pend.push_back(p);
            end
        end
        resp_valid = 1'b0;
        resp_data = 32'h0;
        if (!was_rst && pend.size() > 0 && pend[0].due == cyc) begin
            resp_valid = 1'b1;
            resp_data = ~pend[0].addr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redir = 1'b0; stall = 1'b0; ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int delivered;
        logic [31:0] exp_pc, hold_a;
        logic hold_v;

        tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[3]  = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[4]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C};
        tbl[9]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};
        tbl[10] = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h110};
        tbl[11] = '{1'b0, 1'b1, 32'h11C, 1'b1, 32'h114};
        tbl[12] = '{1'b0, 1'b1, 32'h120, 1'b1, 32'h118};

        rst = 1'b1; ready = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        resp_valid = 1'b0; resp_data = 32'h0; lat = 1;
        tick();
        #1 chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;

        // Reset start, streaming, 4-cycle decode stall with full FIFO
        for (int i = 0; i < 13; i++) begin
            stall = tbl[i].stall;
            #1 chk_out($sformatf("vec%0d", i), tbl[i].rv, tbl[i].addr, tbl[i].iv, tbl[i].pc);
            tick();
        end
        stall = 1'b0;

        // Stale responses: 3-cycle memory, two in flight, redirect to 0x200
        lat = 3;
        do_reset();
        #1 chk_out("stale c0", 1'b1, 32'h100, 1'b0, 32'h0); tick();
        #1 chk_out("stale c1", 1'b1, 32'h104, 1'b0, 32'h0); tick();
        redir = 1'b1; rpc = 32'h200;
        #1 chk_out("stale c2", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        redir = 1'b0;
        #1 chk_out("stale c3", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        #1 chk_out("stale c4", 1'b1, 32'h200, 1'b0, 32'h0); tick();
        #1 chk_out("stale c5", 1'b1, 32'h204, 1'b0, 32'h0); tick();
        #1 chk_out("stale c6", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        #1 chk_out("stale c7", 1'b0, 32'h0, 1'b0, 32'h0); tick();
        #1 chk_out("stale c8", 1'b1, 32'h208, 1'b1, 32'h200); tick();
        #1 chk_id("stale c9", 1'b1, 32'h204); tick();

        // Redirect colliding with a response and an accepted request
        lat = 1;
        do_reset();
        #1 chk_out("coll c0", 1'b1, 32'h100, 1'b0, 32'h0); tick();
        redir = 1'b1; rpc = 32'h203;
        #1 chk_out("coll c1", 1'b1, 32'h104, 1'b0, 32'h0); tick();
        redir = 1'b0;
        #1 chk_out("coll c2", 1'b1, 32'h200, 1'b0, 32'h0); tick();
        #1 chk_out("coll c3", 1'b1, 32'h204, 1'b0, 32'h0); tick();
        #1 chk_out("coll c4", 1'b1, 32'h208, 1'b1, 32'h200); tick();
        #1 chk_id("coll c5", 1'b1, 32'h204); tick();

        // Memory backpressure with random ready and decode stalls
        lat = 2;
        do_reset();
        exp_pc = 32'h100; delivered = 0; hold_v = 1'b0; hold_a = 32'h0;
        for (int i = 0; i < 80; i++) begin
            ready = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 3) == 0);
            #1;
            if (hold_v && req_valid) chk("bp addr hold", req_addr, hold_a);
            if (id_valid && !stall) begin
                chk("bp id_pc", id_pc, exp_pc);
                chk("bp id_inst", id_inst, ~exp_pc);
                exp_pc += 32'd4;
                delivered++;
            end
            hold_v = req_valid && !ready;
            hold_a = req_addr;
            tick();
        end
        chk("bp delivered>=10", 32'(delivered >= 10), 32'h1);
        ready = 1'b1; stall = 1'b0;

        // Address wrap, then reset pulsed mid-stream
        lat = 1;
        do_reset();
        redir = 1'b1; rpc = 32'hFFFF_FFF8;
        #1 chk_out("wrap c0", 1'b1, 32'h100, 1'b0, 32'h0); tick();
        redir = 1'b0;
        #1 chk_out("wrap c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0); tick();
        #1 chk_out("wrap c2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); tick();
        #1 chk_out("wrap c3", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8); tick();
        #1 chk_out("wrap c4", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC); tick();
        rst = 1'b1;
        tick();
        #1 chk_out("midrst", 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        #1 chk_out("midrst rel", 1'b1, 32'h100, 1'b0, 32'h0); tick();
        #1 chk_out("midrst c1", 1'b1, 32'h104, 1'b0, 32'h0); tick();
        #1 chk_id("midrst c2", 1'b1, 32'h100); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
